sram_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port `mem16k` RAM between two bus masters, e.g. a Karuta-generated `mod_main` and a bench-side loader or second design instance. Each requester uses a req/ack handshake. The arbiter grants one transaction at a time, drives the RAM address, write-enable and write-data, and returns registered read data to the winner. It sits directly between the masters and the RAM inside the test bench or the top-level wrapper.

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_arb_pick.sv | 37 +++
 rtl/sram_arbiter.sv | 135 +++++++++++++
 tb/tb_sram_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-requester SRAM arbiter.
package sram_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

    typedef logic grant_t;

    function automatic grant_t other_grant(input grant_t g);
        return ~g;
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner selection for the SRAM arbiter.
// SRAM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties); default is round-robin.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  grant_t last_grant,
    output logic   valid,
    output grant_t winner
);

    assign valid = req0 | req1;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        winner = 1'b0;
        if (!req0 && req1) begin
            winner = 1'b1;
        end
    end
`else
    // On a tie the requester that was not served last goes next.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = other_grant(last_grant);
        end else if (req1) begin
            winner = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port RAM between two req/ack masters, one transaction every three cycles.
// Arbitration policy is chosen inside sram_arb_pick via SRAM_ARB_FIXED_PRIO_EN.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_i,
    input  logic                  wen0_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic                  req1_i,
    input  logic                  wen1_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    output logic                  ack0_o,
    output logic                  ack1_o,
    output logic [DATA_WIDTH-1:0] rdata0_o,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  write_en_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    input  logic [DATA_WIDTH-1:0] rdata_i
);

    state_t                state_reg, state_next;
    grant_t                grant_reg, grant_next;
    grant_t                last_grant_reg, last_grant_next;
    logic                  wen_reg, wen_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic                  write_en_next;
    logic                  ack0_next, ack1_next;
    logic [DATA_WIDTH-1:0] rdata0_next, rdata1_next;

    logic   pick_valid;
    grant_t pick_winner;

    sram_arb_pick u_pick (
        .req0       (req0_i),
        .req1       (req1_i),
        .last_grant (last_grant_reg),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        wen_next        = wen_reg;
        addr_next       = addr_o;
        wdata_next      = wdata_o;
        write_en_next   = 1'b0;
        ack0_next       = 1'b0;
        ack1_next       = 1'b0;
        rdata0_next     = rdata0_o;
        rdata1_next     = rdata1_o;

        case (state_reg)
            IDLE: begin
                // The RAM-side registers are loaded here so they are already valid during ISSUE.
                if (pick_valid) begin
                    grant_next = pick_winner;
                    if (pick_winner) begin
                        wen_next      = wen1_i;
                        addr_next     = addr1_i;
                        wdata_next    = wdata1_i;
                        write_en_next = wen1_i;
                    end else begin
                        wen_next      = wen0_i;
                        addr_next     = addr0_i;
                        wdata_next    = wdata0_i;
                        write_en_next = wen0_i;
                    end
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = ACK;
            end
            ACK: begin
                if (grant_reg) begin
                    ack1_next = 1'b1;
                    if (!wen_reg) begin
                        rdata1_next = rdata_i;
                    end
                end else begin
                    ack0_next = 1'b1;
                    if (!wen_reg) begin
                        rdata0_next = rdata_i;
                    end
                end
                last_grant_next = grant_reg;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            wen_reg        <= 1'b0;
            addr_o         <= '0;
            wdata_o        <= '0;
            write_en_o     <= 1'b0;
            ack0_o         <= 1'b0;
            ack1_o         <= 1'b0;
            rdata0_o       <= '0;
            rdata1_o       <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            wen_reg        <= wen_next;
            addr_o         <= addr_next;
            wdata_o        <= wdata_next;
            write_en_o     <= write_en_next;
            ack0_o         <= ack0_next;
            ack1_o         <= ack1_next;
            rdata0_o       <= rdata0_next;
            rdata1_o       <= rdata1_next;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized self-checking bench for sram_arbiter with a transaction-level reference model.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic        wen   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ack0, ack1, write_en;
    logic [31:0] rdata0, rdata1, addr_out, wdata_out;
    logic [31:0] rdata_ram;
    logic [31:0] ram [4096];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] ref_mem [64];
    logic [31:0] held    [2];
    bit          lg;
    logic [31:0] m_addr, m_wdata;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_i     (req[0]),
        .wen0_i     (wen[0]),
        .addr0_i    (addr[0]),
        .wdata0_i   (wdata[0]),
        .req1_i     (req[1]),
        .wen1_i     (wen[1]),
        .addr1_i    (addr[1]),
        .wdata1_i   (wdata[1]),
        .ack0_o     (ack0),
        .ack1_o     (ack1),
        .rdata0_o   (rdata0),
        .rdata1_o   (rdata1),
        .addr_o     (addr_out),
        .write_en_o (write_en),
        .wdata_o    (wdata_out),
        .rdata_i    (rdata_ram)
    );

    // Behavioural single-port RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (write_en) ram[addr_out[13:2]] <= wdata_out;
        rdata_ram <= ram[addr_out[13:2]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs(input bit exp_we, input bit exp_a0, input bit exp_a1);
        check("ack0", 64'(ack0), 64'(exp_a0));
        check("ack1", 64'(ack1), 64'(exp_a1));
        check("write_en", 64'(write_en), 64'(exp_we));
        check("addr_o", 64'(addr_out), 64'(m_addr));
        check("wdata_o", 64'(wdata_out), 64'(m_wdata));
        check("rdata0", 64'(rdata0), 64'(held[0]));
        check("rdata1", 64'(rdata1), 64'(held[1]));
    endtask

    task automatic model_reset();
        lg      = 1'b1;
        held[0] = '0;
        held[1] = '0;
        m_addr  = '0;
        m_wdata = '0;
    endtask

    // One arbitration round: present up to two requests together, follow both transactions
    // through the fixed 3-cycle cadence, and compare every output every cycle.
    task automatic do_round(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                            input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                            input bit early);
        bit          two, first, second, ea0, ea1, ewe;
        bit          tw [2];
        logic [31:0] ta [2];
        logic [31:0] td [2];
        int          g;
        two   = r0 && r1;
        tw[0] = w0; ta[0] = a0; td[0] = d0;
        tw[1] = w1; ta[1] = a1; td[1] = d1;
        if (two) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            first = 1'b0;
`else
            first = ~lg;
`endif
        end else begin
            first = r1;
        end
        second = ~first;
        req[0] = r0; wen[0] = w0; addr[0] = a0; wdata[0] = d0;
        req[1] = r1; wen[1] = w1; addr[1] = a1; wdata[1] = d1;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            @(negedge clk);
            ewe = 1'b0; ea0 = 1'b0; ea1 = 1'b0;
            g = -1;
            if (c == 0 || (c == 3 && two)) begin
                g       = (c == 0) ? int'(first) : int'(second);
                ewe     = tw[g];
                m_addr  = ta[g];
                m_wdata = td[g];
            end
            if (c == 2 || (c == 5 && two)) begin
                g = (c == 2) ? int'(first) : int'(second);
                if (g == 0) ea0 = 1'b1; else ea1 = 1'b1;
                lg = g[0];
                if (tw[g]) ref_mem[ta[g][7:2]] = td[g];
                else       held[g] = ref_mem[ta[g][7:2]];
            end
            check_outputs(ewe, ea0, ea1);
            if (c == 0) begin
                // Fields are latched at grant, so the winner may now change them freely.
                wen[first]   = 1'($urandom_range(0, 1));
                addr[first]  = $urandom;
                wdata[first] = $urandom;
                if (early) req[first] = 1'b0;
            end
            if (c == 2) req[first] = 1'b0;
            if (c == 5) req[second] = 1'b0;
        end
    endtask

    task automatic reset_mid_write();
        req[0] = 1'b1; wen[0] = 1'b1; addr[0] = 32'h100; wdata[0] = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        check("rst_pre_we", 64'(write_en), 64'd1);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_outputs(1'b0, 1'b0, 1'b0);
        req[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_outputs(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        bit          r0, r1, early;
        logic [31:0] a0, a1;
        for (int i = 0; i < 4096; i++) ram[i] = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; wen[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_outputs(1'b0, 1'b0, 1'b0);

        // Tie straight after reset, then the directed write/read/hold/early-drop cases.
        do_round(1, 0, 32'h40, 32'h0, 1, 0, 32'h80, 32'h0, 0);
        do_round(1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0, 0);
        do_round(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        do_round(1, 1, 32'h44, 32'h0000_55AA, 0, 0, 32'h0, 32'h0, 0);
        do_round(0, 0, 32'h0, 32'h0, 1, 1, 32'h80, 32'h12345678, 1);
        do_round(0, 0, 32'h0, 32'h0, 1, 0, 32'h80, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            do_round(1, 0, 32'h40, 32'h0, 1, 0, 32'h80, 32'h0, 0);
        end

        reset_mid_write();
        do_round(1, 0, 32'h44, 32'h0, 1, 0, 32'h40, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            early = !(r0 && r1) && ($urandom_range(0, 3) == 0);
            a0 = 32'($urandom_range(0, 255));
            a1 = 32'($urandom_range(0, 255));
            do_round(r0, 1'($urandom_range(0, 1)), a0, $urandom,
                     r1, 1'($urandom_range(0, 1)), a1, $urandom, early);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
